// File: rtl/v2x_hsm_pkg.sv
// Shared constants, SHA register map and router state encoding for the V2X HSM
// command router.
package v2x_hsm_pkg;

  localparam logic [7:0]  OP_SHA256        = 8'h00;
  localparam logic [7:0]  ADDR_CTRL        = 8'h08;
  localparam logic [7:0]  ADDR_STATUS      = 8'h09;
  localparam logic [7:0]  ADDR_BLOCK0      = 8'h10;
  localparam logic [7:0]  ADDR_DIGEST0     = 8'h20;
  localparam logic [31:0] CTRL_INIT_SHA256 = 32'h0000_0005;

  localparam int unsigned MAX_LEN = 55;

  localparam int unsigned SB_BUSY   = 0;
  localparam int unsigned SB_DONE   = 1;
  localparam int unsigned SB_ERR    = 2;
  localparam int unsigned SB_BADCMD = 3;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RX_DATA   = 4'd1,
    S_WRITE_BLK = 4'd2,
    S_START     = 4'd3,
    S_POLL      = 4'd4,
    S_READ_DIG  = 4'd5,
    S_TX_HI     = 4'd6,
    S_TX_LO     = 4'd7,
    S_DONE      = 4'd8,
    S_ERR       = 4'd9
  } state_e;

endpackage

// File: rtl/v2x_sha_block_packer.sv
// Payload byte buffer; produces SHA-256 single-block padded word k on demand
// from the buffered bytes and the message length.
module v2x_sha_block_packer
  import v2x_hsm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        wr_i,
  input  logic [15:0] wr_word_i,
  input  logic [5:0]  len_i,
  input  logic [3:0]  word_idx_i,
  output logic [31:0] word_o
);

  localparam int unsigned BUF_BYTES = MAX_LEN + 1;

  logic [7:0]  byte_q [BUF_BYTES];
  logic [4:0]  wptr_q;
  logic [31:0] base;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
    end else if (wr_i) begin
      wptr_q <= wptr_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_i && !clear_i && (wptr_q < 5'd28)) begin
      byte_q[{wptr_q, 1'b0}] <= wr_word_i[15:8];
      byte_q[{wptr_q, 1'b1}] <= wr_word_i[7:0];
    end
  end

  // Bytes past LEN are masked, so stale buffer contents never reach the core.
  function automatic logic [7:0] pad_byte(input logic [31:0] j);
    if (j < 32'(len_i)) return byte_q[j[5:0]];
    if (j == 32'(len_i)) return 8'h80;
    return 8'h00;
  endfunction

  assign base = {26'd0, word_idx_i, 2'b00};

  always_comb begin
    word_o = '0;
    if (word_idx_i == 4'd15) begin
      word_o = {23'd0, len_i, 3'd0};
    end else begin
      word_o = {pad_byte(base), pad_byte(base + 32'd1),
                pad_byte(base + 32'd2), pad_byte(base + 32'd3)};
    end
  end

endmodule

// File: rtl/v2x_protocol_router.sv
// Routes SPI commands to the SHA-256 core: collects payload, writes the padded
// block, starts and polls the core, then streams the digest back over SPI.
module v2x_protocol_router
  import v2x_hsm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned POLL_TIMEOUT = 4096
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic [DATA_WIDTH-1:0] i_spi_rx_data,
  input  logic                  i_spi_rx_valid,
  output logic [DATA_WIDTH-1:0] o_spi_tx_data,
  output logic                  o_spi_tx_valid,
  input  logic                  i_spi_tx_ready,
  output logic                  o_spi_busy,
  output logic                  o_sha_cs,
  output logic                  o_sha_we,
  output logic [7:0]            o_sha_address,
  output logic [31:0]           o_sha_write_data,
  input  logic [31:0]           i_sha_read_data,
  input  logic                  i_sha_error,
  output logic [7:0]            o_status_reg,
  output logic                  o_operation_complete
);

  localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);

  state_e          state_q;
  logic [5:0]      len_q;
  logic [4:0]      rx_cnt_q, blk_cnt_q, rx_words;
  logic [2:0]      dig_k_q;
  logic            rd_phase_q;
  logic [PW-1:0]   poll_cnt_q;
  logic [31:0]     cap_q, blk_word;
  logic [15:0]     tx_data_q;
  logic            tx_valid_q, busy_q, cs_q, we_q, cmpl_q;
  logic [7:0]      addr_q;
  logic [31:0]     wdata_q;
  logic            done_q, err_q, bad_q;
  logic            sha_active, pk_clear, pk_wr, cmd_bad;
  logic [7:0]      cmd_op, cmd_len;

  assign cmd_op     = i_spi_rx_data[7:0];
  assign cmd_len    = i_spi_rx_data[15:8];
  assign cmd_bad    = (cmd_op != OP_SHA256) || (cmd_len > 8'(MAX_LEN));
  assign rx_words   = 5'((7'(len_q) + 7'd1) >> 1);
  assign sha_active = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign pk_clear   = (state_q == S_IDLE) && i_spi_rx_valid;
  assign pk_wr      = (state_q == S_RX_DATA) && i_spi_rx_valid;

  v2x_sha_block_packer u_packer (
    .clk_i      (i_sys_clk),
    .rst_i      (i_sys_rst),
    .clear_i    (pk_clear),
    .wr_i       (pk_wr),
    .wr_word_i  (i_spi_rx_data),
    .len_i      (len_q),
    .word_idx_i (blk_cnt_q[3:0]),
    .word_o     (blk_word)
  );

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rx_cnt_q   <= '0;
      blk_cnt_q  <= '0;
      dig_k_q    <= '0;
      rd_phase_q <= 1'b0;
      poll_cnt_q <= '0;
      cap_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bad_q      <= 1'b0;
      cmpl_q     <= 1'b0;
    end else begin
      cmpl_q <= 1'b0;
      if (sha_active && i_sha_error) begin
        state_q    <= S_ERR;
        cs_q       <= 1'b0;
        we_q       <= 1'b0;
        addr_q     <= '0;
        wdata_q    <= '0;
        tx_valid_q <= 1'b0;
        tx_data_q  <= '0;
        err_q      <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: if (i_spi_rx_valid) begin
            done_q <= 1'b0;
            err_q  <= cmd_bad;
            bad_q  <= cmd_bad;
            if (!cmd_bad) begin
              busy_q    <= 1'b1;
              len_q     <= cmd_len[5:0];
              rx_cnt_q  <= '0;
              blk_cnt_q <= '0;
              state_q   <= (cmd_len == 8'd0) ? S_WRITE_BLK : S_RX_DATA;
            end
          end
          S_RX_DATA: if (i_spi_rx_valid) begin
            if (rx_cnt_q == rx_words - 5'd1) state_q <= S_WRITE_BLK;
            else                            rx_cnt_q <= rx_cnt_q + 5'd1;
          end
          // One setup cycle lets the last payload word settle in the packer
          // before block word 0 is presented.
          S_WRITE_BLK: begin
            cs_q <= 1'b1;
            we_q <= 1'b1;
            if (blk_cnt_q[4]) begin
              addr_q  <= ADDR_CTRL;
              wdata_q <= CTRL_INIT_SHA256;
              state_q <= S_START;
            end else begin
              addr_q    <= ADDR_BLOCK0 + {4'd0, blk_cnt_q[3:0]};
              wdata_q   <= blk_word;
              blk_cnt_q <= blk_cnt_q + 5'd1;
            end
          end
          S_START: begin
            we_q       <= 1'b0;
            addr_q     <= ADDR_STATUS;
            wdata_q    <= '0;
            poll_cnt_q <= '0;
            state_q    <= S_POLL;
          end
          S_POLL: begin
            if (i_sha_read_data[1:0] == 2'b11) begin
              addr_q     <= ADDR_DIGEST0;
              dig_k_q    <= '0;
              rd_phase_q <= 1'b0;
              state_q    <= S_READ_DIG;
            end else if (poll_cnt_q == PW'(POLL_TIMEOUT - 1)) begin
              cs_q    <= 1'b0;
              addr_q  <= '0;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_ERR;
            end else begin
              poll_cnt_q <= poll_cnt_q + PW'(1);
            end
          end
          S_READ_DIG: begin
            if (!rd_phase_q) begin
              rd_phase_q <= 1'b1;
            end else begin
              cap_q      <= i_sha_read_data;
              tx_data_q  <= i_sha_read_data[31:16];
              tx_valid_q <= 1'b1;
              cs_q       <= 1'b0;
              addr_q     <= '0;
              state_q    <= S_TX_HI;
            end
          end
          S_TX_HI: if (i_spi_tx_ready) begin
            tx_data_q <= cap_q[15:0];
            state_q   <= S_TX_LO;
          end
          S_TX_LO: if (i_spi_tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            if (dig_k_q == 3'd7) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              cmpl_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              dig_k_q    <= dig_k_q + 3'd1;
              cs_q       <= 1'b1;
              addr_q     <= ADDR_DIGEST0 + {5'd0, 3'(dig_k_q + 3'd1)};
              rd_phase_q <= 1'b0;
              state_q    <= S_READ_DIG;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          S_ERR:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    o_status_reg            = '0;
    o_status_reg[SB_BUSY]   = busy_q;
    o_status_reg[SB_DONE]   = done_q;
    o_status_reg[SB_ERR]    = err_q;
    o_status_reg[SB_BADCMD] = bad_q;
    o_status_reg[7:4]       = state_q;
  end

  assign o_spi_tx_data        = tx_data_q;
  assign o_spi_tx_valid       = tx_valid_q;
  assign o_spi_busy           = busy_q;
  assign o_sha_cs             = cs_q;
  assign o_sha_we             = we_q;
  assign o_sha_address        = addr_q;
  assign o_sha_write_data     = wdata_q;
  assign o_operation_complete = cmpl_q;

endmodule

// File: tb/tb_v2x_protocol_router.sv
// Directed bench for v2x_protocol_router with a stub SHA register file.
module tb_v2x_protocol_router;
  import v2x_hsm_pkg::*;

  localparam int unsigned TB_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy, cs, we, cmpl;
  logic [7:0]  addr, status;
  logic [31:0] wdata, sha_rd;
  logic        sha_err = 1'b0;
  logic [31:0] stub_status = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  v2x_protocol_router #(.DATA_WIDTH(16), .POLL_TIMEOUT(TB_TIMEOUT)) dut (
    .i_sys_clk            (clk),
    .i_sys_rst            (rst),
    .i_spi_rx_data        (rx_data),
    .i_spi_rx_valid       (rx_valid),
    .o_spi_tx_data        (tx_data),
    .o_spi_tx_valid       (tx_valid),
    .i_spi_tx_ready       (tx_ready),
    .o_spi_busy           (busy),
    .o_sha_cs             (cs),
    .o_sha_we             (we),
    .o_sha_address        (addr),
    .o_sha_write_data     (wdata),
    .i_sha_read_data      (sha_rd),
    .i_sha_error          (sha_err),
    .o_status_reg         (status),
    .o_operation_complete (cmpl)
  );

  always_comb begin
    sha_rd = '0;
    if (addr == 8'h09) sha_rd = stub_status;
    else if (addr[7:3] == 5'b00100) sha_rd = {16'hDEAD, 13'd0, addr[2:0]};
  end

  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [15:0] tx_q[$];
  int cs_cycles = 0, cmpl_cnt = 0, poll_cycles = 0, stab_err = 0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (cs && we) begin
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(wdata);
    end
    if (cs) cs_cycles++;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (cmpl) cmpl_cnt++;
    if (status[7:4] == 4'(S_POLL)) poll_cycles++;
    if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err++;
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  task automatic send_word(input logic [15:0] w);
    @(posedge clk); #1;
    rx_data = w; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && status[7:4] == 4'd0) begin ok = 1'b1; break; end
    end
    #1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_idle_timeout status=%h busy=%b required idle within %0d cycles", tag, status, busy, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (status !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", status); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if ({tx_data, tx_valid, cs, we, addr, wdata, cmpl} !== '0) begin
      failures++;
      $display("FAIL reset_outputs tx=%h v=%b cs=%b we=%b a=%h d=%h c=%b exp all 0", tx_data, tx_valid, cs, we, addr, wdata, cmpl);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sha_ab();
    int wa0 = wr_addr_q.size(), tx0 = tx_q.size(), c0 = cmpl_cnt;
    logic [7:0]  ea[17];
    logic [31:0] ed[17];
    logic [15:0] et;
    for (int i = 0; i < 16; i++) begin ea[i] = 8'h10 + 8'(i); ed[i] = 32'h0; end
    ed[0] = 32'h6162_8000; ed[15] = 32'h0000_0010;
    ea[16] = 8'h08; ed[16] = 32'h0000_0005;
    stub_status = 32'h3; tx_ready = 1'b1;
    send_word(16'h0200);
    checks++;
    if (busy !== 1'b1 || status[0] !== 1'b1) begin failures++; $display("FAIL ab_busy busy=%b status=%h exp busy=1", busy, status); end
    send_word(16'h6162);
    wait_idle(400, "ab");
    checks++;
    if (wr_addr_q.size() - wa0 != 17) begin
      failures++; $display("FAIL ab_wr_count got=%0d exp=17", wr_addr_q.size() - wa0);
    end else begin
      for (int i = 0; i < 17; i++) begin
        checks++;
        if (wr_addr_q[wa0+i] !== ea[i] || wr_data_q[wa0+i] !== ed[i]) begin
          failures++;
          $display("FAIL ab_wr%0d got=%h:%h exp=%h:%h", i, wr_addr_q[wa0+i], wr_data_q[wa0+i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (tx_q.size() - tx0 != 16) begin
      failures++; $display("FAIL ab_tx_count got=%0d exp=16", tx_q.size() - tx0);
    end else begin
      for (int i = 0; i < 16; i++) begin
        et = (i % 2 == 0) ? 16'hDEAD : 16'(i / 2);
        checks++;
        if (tx_q[tx0+i] !== et) begin failures++; $display("FAIL ab_tx%0d got=%h exp=%h", i, tx_q[tx0+i], et); end
      end
    end
    checks++;
    if (cmpl_cnt - c0 != 1) begin failures++; $display("FAIL ab_complete got=%0d exp=1", cmpl_cnt - c0); end
    checks++;
    if (status !== 8'h02) begin failures++; $display("FAIL ab_status got=%h exp=02", status); end
  endtask

  task automatic test_odd_len();
    int wa0 = wr_addr_q.size();
    stub_status = 32'h3; tx_ready = 1'b1;
    send_word(16'h0300);
    send_word(16'h6162);
    send_word(16'h63FF);
    wait_idle(400, "odd");
    checks++;
    if (wr_addr_q.size() - wa0 != 17) begin
      failures++; $display("FAIL odd_wr_count got=%0d exp=17", wr_addr_q.size() - wa0);
    end else begin
      checks++;
      if (wr_data_q[wa0] !== 32'h6162_6380) begin failures++; $display("FAIL odd_word0 got=%h exp=61626380", wr_data_q[wa0]); end
      checks++;
      if (wr_data_q[wa0+15] !== 32'h0000_0018) begin failures++; $display("FAIL odd_word15 got=%h exp=00000018", wr_data_q[wa0+15]); end
    end
  endtask

  task automatic test_tx_stall();
    int wa0 = wr_addr_q.size(), tx0 = tx_q.size(), s0 = stab_err;
    bit seen = 1'b0;
    logic [15:0] et;
    stub_status = 32'h3; tx_ready = 1'b0;
    send_word(16'h0000);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL stall_valid_timeout valid=%b exp=1 within 200 cycles", tx_valid); end
    repeat (5) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 16'hDEAD) begin
      failures++; $display("FAIL stall_hold valid=%b data=%h exp 1/DEAD", tx_valid, tx_data);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_idle(400, "stall");
    checks++;
    if (stab_err != s0) begin failures++; $display("FAIL stall_stability violations=%0d exp=0", stab_err - s0); end
    checks++;
    if (tx_q.size() - tx0 != 16) begin
      failures++; $display("FAIL stall_tx_count got=%0d exp=16", tx_q.size() - tx0);
    end else begin
      for (int i = 0; i < 16; i++) begin
        et = (i % 2 == 0) ? 16'hDEAD : 16'(i / 2);
        checks++;
        if (tx_q[tx0+i] !== et) begin failures++; $display("FAIL stall_tx%0d got=%h exp=%h", i, tx_q[tx0+i], et); end
      end
    end
    checks++;
    if (wr_addr_q.size() - wa0 != 17) begin
      failures++; $display("FAIL len0_wr_count got=%0d exp=17", wr_addr_q.size() - wa0);
    end else begin
      checks++;
      if (wr_data_q[wa0] !== 32'h8000_0000) begin failures++; $display("FAIL len0_word0 got=%h exp=80000000", wr_data_q[wa0]); end
      checks++;
      if (wr_data_q[wa0+15] !== 32'h0) begin failures++; $display("FAIL len0_word15 got=%h exp=00000000", wr_data_q[wa0+15]); end
    end
  endtask

  task automatic test_bad_cmd();
    int cs0 = cs_cycles;
    send_word(16'h0201);
    @(negedge clk);
    checks++;
    if (status !== 8'h0C || busy !== 1'b0) begin failures++; $display("FAIL bad_opcode status=%h busy=%b exp 0C/0", status, busy); end
    send_word(16'h3800);
    @(negedge clk);
    checks++;
    if (status !== 8'h0C || busy !== 1'b0) begin failures++; $display("FAIL bad_len56 status=%h busy=%b exp 0C/0", status, busy); end
    repeat (3) @(negedge clk);
    checks++;
    if (cs_cycles != cs0) begin failures++; $display("FAIL bad_no_sha cs_cycles=%0d exp=0", cs_cycles - cs0); end
  endtask

  task automatic test_sha_error();
    int c0 = cmpl_cnt;
    bit seen = 1'b0;
    stub_status = 32'h0;
    send_word(16'h0000);
    checks++;
    if (status[3:1] !== 3'b000 || busy !== 1'b1) begin failures++; $display("FAIL err_accept status=%h busy=%b exp bits3:1=0 busy=1", status, busy); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (status[7:4] == 4'(S_POLL)) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL err_poll_timeout state=%h exp POLL within 100 cycles", status[7:4]); end
    @(posedge clk); #1; sha_err = 1'b1;
    @(posedge clk); #1; sha_err = 1'b0;
    checks++;
    if (cs !== 1'b0 || tx_valid !== 1'b0 || status[2] !== 1'b1 || status[7:4] !== 4'(S_ERR)) begin
      failures++; $display("FAIL err_state cs=%b v=%b status=%h exp cs=0 v=0 bit2=1 ERR", cs, tx_valid, status);
    end
    @(posedge clk); #1;
    checks++;
    if (status !== 8'h04 || busy !== 1'b0) begin failures++; $display("FAIL err_idle status=%h busy=%b exp 04/0", status, busy); end
    checks++;
    if (cmpl_cnt != c0) begin failures++; $display("FAIL err_no_complete got=%0d exp=0", cmpl_cnt - c0); end
  endtask

  task automatic test_timeout();
    int p0 = poll_cycles, c0 = cmpl_cnt, tx0 = tx_q.size();
    stub_status = 32'h2;
    send_word(16'h0000);
    checks++;
    if (status[2] !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_accept status=%h busy=%b exp bit2=0 busy=1", status, busy); end
    wait_idle(TB_TIMEOUT + 100, "to");
    checks++;
    if (poll_cycles - p0 != TB_TIMEOUT) begin failures++; $display("FAIL to_poll_cycles got=%0d exp=%0d", poll_cycles - p0, TB_TIMEOUT); end
    checks++;
    if (status !== 8'h04) begin failures++; $display("FAIL to_status got=%h exp=04", status); end
    checks++;
    if (cmpl_cnt != c0 || tx_q.size() != tx0) begin
      failures++; $display("FAIL to_no_output complete=%0d tx=%0d exp 0/0", cmpl_cnt - c0, tx_q.size() - tx0);
    end
  endtask

  task automatic test_reset_abort();
    stub_status = 32'h3;
    send_word(16'h0400);
    send_word(16'h1234);
    checks++;
    if (status[7:4] !== 4'(S_RX_DATA)) begin failures++; $display("FAIL abort_pre state=%h exp=%h", status[7:4], 4'(S_RX_DATA)); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (status !== 8'h00 || busy !== 1'b0 || cs !== 1'b0 || tx_valid !== 1'b0) begin
      failures++; $display("FAIL abort_outputs status=%h busy=%b cs=%b v=%b exp all 0", status, busy, cs, tx_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sha_ab();
    test_odd_len();
    test_tx_stall();
    test_bad_cmd();
    test_sha_error();
    test_timeout();
    test_reset_abort();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
